// File: rtl/compressor_pkg.sv
// rtl/compressor_pkg.sv - shared byte/window types and arbiter state encoding for the compressor return path
package compressor_pkg;

    localparam int NUM_BYTES_INPUT_WIDTH = 16;
    localparam int NUM_UNCOMPRESSED_ELEMENTS = 34;
    localparam int BV_W = $clog2(NUM_UNCOMPRESSED_ELEMENTS);

    typedef logic [7:0] FifoByte_t;
    typedef FifoByte_t [NUM_BYTES_INPUT_WIDTH-1:0] Window_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } ArbState_t;

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational round-robin pick starting one past the last served lane
module rr_priority_pick #(
    parameter int N = 4,
    localparam int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] lastId,
    output logic [ID_W-1:0] winner,
    output logic            anyRequest
);

    logic [ID_W-1:0] idx;

    always_comb begin
        winner     = '0;
        anyRequest = 1'b0;
        idx        = '0;
        for (int k = 1; k <= N; k++) begin
            idx = ID_W'((int'(lastId) + k) % N);
            if (!anyRequest && req[idx]) begin
                winner     = idx;
                anyRequest = 1'b1;
            end
        end
    end

endmodule

// File: rtl/return_fifo_arbiter.sv
// rtl/return_fifo_arbiter.sv - block-granular round-robin sharing of the ReturnFIFO write port
module return_fifo_arbiter
    import compressor_pkg::*;
#(
    parameter int NUM_REQUESTERS = 4,
    parameter int BYTE_COUNT_W = 16,
    localparam int ID_W = $clog2(NUM_REQUESTERS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  Window_t [NUM_REQUESTERS-1:0]  reqDataIn,
    input  logic [NUM_REQUESTERS-1:0][BV_W-1:0] reqBytesValid,
    input  logic [NUM_REQUESTERS-1:0]     reqEndOfBlock,
    output logic [NUM_REQUESTERS-1:0]     reqShift,
    output Window_t                       fifoDataIn,
    output logic [BV_W-1:0]               fifoBytesValid,
    input  logic                          fifoShift,
    output logic                          grantValid,
    output logic [ID_W-1:0]               grantId,
    output logic                          blockDone,
    output logic [BYTE_COUNT_W-1:0]       blockByteCount
);

    localparam int SUM_W = BYTE_COUNT_W + 1;
    localparam logic [BV_W-1:0] WIN_BYTES = BV_W'(NUM_BYTES_INPUT_WIDTH);

    ArbState_t                   state;
    logic [ID_W-1:0]             lastId;
    logic [BYTE_COUNT_W-1:0]     acc;
    logic [NUM_REQUESTERS-1:0]   requesting;
    logic [ID_W-1:0]             winner;
    logic                        anyRequest;
    logic [BV_W-1:0]             g_bv;
    logic                        g_eob;
    logic [BV_W-1:0]             chunk;
    logic [SUM_W-1:0]            sum;
    logic [BYTE_COUNT_W-1:0]     acc_next;
    logic                        complete;

    always_comb begin
        requesting = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            requesting[i] = (reqBytesValid[i] != '0) || reqEndOfBlock[i];
        end
    end

    rr_priority_pick #(.N(NUM_REQUESTERS)) u_pick (
        .req        (requesting),
        .lastId     (lastId),
        .winner     (winner),
        .anyRequest (anyRequest)
    );

    assign g_bv  = reqBytesValid[grantId];
    assign g_eob = reqEndOfBlock[grantId];

    // Without a grant the FIFO sees zero valid bytes, so it can never take data.
    always_comb begin
        fifoDataIn     = '0;
        fifoBytesValid = '0;
        reqShift       = '0;
        if (grantValid) begin
            fifoDataIn        = reqDataIn[grantId];
            fifoBytesValid    = g_bv;
            reqShift[grantId] = fifoShift;
        end
    end

    assign chunk    = (g_bv > WIN_BYTES) ? WIN_BYTES : g_bv;
    assign sum      = {1'b0, acc} + SUM_W'(chunk);
    assign acc_next = !fifoShift ? acc : (sum[BYTE_COUNT_W] ? '1 : sum[BYTE_COUNT_W-1:0]);
    // An end-of-block flag only releases once the remaining bytes fit a single window.
    assign complete = g_eob && ((g_bv == '0) || (fifoShift && (g_bv <= WIN_BYTES)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            grantValid     <= 1'b0;
            grantId        <= '0;
            lastId         <= ID_W'(NUM_REQUESTERS - 1);
            acc            <= '0;
            blockDone      <= 1'b0;
            blockByteCount <= '0;
        end else begin
            blockDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (anyRequest) begin
                        state      <= GRANT;
                        grantValid <= 1'b1;
                        grantId    <= winner;
                        acc        <= '0;
                    end
                end
                GRANT: begin
                    if (complete) begin
                        state          <= IDLE;
                        grantValid     <= 1'b0;
                        lastId         <= grantId;
                        blockDone      <= 1'b1;
                        blockByteCount <= acc_next;
                    end
                    acc <= acc_next;
                end
                default: begin
                    state      <= IDLE;
                    grantValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_return_fifo_arbiter.sv
// tb/tb_return_fifo_arbiter.sv - directed per-cycle vector bench for return_fifo_arbiter
module tb_return_fifo_arbiter;

    logic                   clk;
    logic                   reset;
    logic [3:0][15:0][7:0]  reqDataIn;
    logic [3:0][5:0]        reqBytesValid;
    logic [3:0]             reqEndOfBlock;
    logic [3:0]             reqShift;
    logic [15:0][7:0]       fifoDataIn;
    logic [5:0]             fifoBytesValid;
    logic                   fifoShift;
    logic                   grantValid;
    logic [1:0]             grantId;
    logic                   blockDone;
    logic [15:0]            blockByteCount;

    int tests_run = 0;
    int tests_failed = 0;

    return_fifo_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .reqDataIn      (reqDataIn),
        .reqBytesValid  (reqBytesValid),
        .reqEndOfBlock  (reqEndOfBlock),
        .reqShift       (reqShift),
        .fifoDataIn     (fifoDataIn),
        .fifoBytesValid (fifoBytesValid),
        .fifoShift      (fifoShift),
        .grantValid     (grantValid),
        .grantId        (grantId),
        .blockDone      (blockDone),
        .blockByteCount (blockByteCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0][5:0] bv;
        logic [3:0]      eob;
        logic            fs;
        logic            e_gv;
        logic [1:0]      e_gid;
        logic [3:0]      e_sh;
        logic            e_done;
        logic [15:0]     e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int b3, input int b2, input int b1, input int b0,
                                input int eob, input int fs, input int gv, input int gid,
                                input int sh, input int done, input int cnt);
        vec_t v;
        v.bv[3]  = 6'(b3);
        v.bv[2]  = 6'(b2);
        v.bv[1]  = 6'(b1);
        v.bv[0]  = 6'(b0);
        v.eob    = 4'(eob);
        v.fs     = 1'(fs);
        v.e_gv   = 1'(gv);
        v.e_gid  = 2'(gid);
        v.e_sh   = 4'(sh);
        v.e_done = 1'(done);
        v.e_cnt  = 16'(cnt);
        return v;
    endfunction

    task automatic chk(input string tag, input string name, input logic [127:0] act, input logic [127:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s %s: got %0h expected %0h", tag, name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input logic rst, input string tag);
        logic [127:0] exp_d;
        logic [5:0]   exp_bv;
        reset         = rst;
        reqBytesValid = v.bv;
        reqEndOfBlock = v.eob;
        fifoShift     = v.fs;
        exp_bv = v.e_gv ? v.bv[v.e_gid] : 6'd0;
        exp_d  = v.e_gv ? reqDataIn[v.e_gid] : 128'd0;
        @(negedge clk);
        chk(tag, "grantValid", 128'(grantValid), 128'(v.e_gv));
        if (v.e_gv) chk(tag, "grantId", 128'(grantId), 128'(v.e_gid));
        chk(tag, "reqShift", 128'(reqShift), 128'(v.e_sh));
        chk(tag, "fifoBytesValid", 128'(fifoBytesValid), 128'(exp_bv));
        chk(tag, "fifoDataIn", fifoDataIn, exp_d);
        chk(tag, "blockDone", 128'(blockDone), 128'(v.e_done));
        if (v.e_done) chk(tag, "blockByteCount", 128'(blockByteCount), 128'(v.e_cnt));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        reqBytesValid = '0;
        reqEndOfBlock = '0;
        fifoShift     = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset", "grantValid", 128'(grantValid), 128'd0);
        chk("reset", "grantId", 128'(grantId), 128'd0);
        chk("reset", "blockDone", 128'(blockDone), 128'd0);
        chk("reset", "blockByteCount", 128'(blockByteCount), 128'd0);
        chk("reset", "fifoBytesValid", 128'(fifoBytesValid), 128'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i < hi; i++) apply(tbl[i], 1'b0, $sformatf("row%0d", i));
    endtask

    initial begin
        for (int i = 0; i < 4; i++)
            for (int b = 0; b < 16; b++)
                reqDataIn[i][b] = 8'(i * 16 + b);

        // Single lane 2, 40-byte block in three windows.
        tbl.push_back(mk(0, 40, 0, 0, 'b0000, 1, 0, 0, 'b0000, 0, 0));
        tbl.push_back(mk(0, 40, 0, 0, 'b0000, 1, 1, 2, 'b0100, 0, 0));
        tbl.push_back(mk(0, 24, 0, 0, 'b0000, 1, 1, 2, 'b0100, 0, 0));
        tbl.push_back(mk(0,  8, 0, 0, 'b0100, 1, 1, 2, 'b0100, 0, 0));
        tbl.push_back(mk(0,  0, 0, 0, 'b0000, 1, 0, 0, 'b0000, 1, 40));
        tbl.push_back(mk(0,  0, 0, 0, 'b0000, 1, 0, 0, 'b0000, 0, 0));
        // Round-robin over lanes 0,1,3; lane 0 re-requests right after its block.
        tbl.push_back(mk(8, 0, 8, 8, 'b1011, 1, 0, 0, 'b0000, 0, 0));
        tbl.push_back(mk(8, 0, 8, 8, 'b1011, 1, 1, 0, 'b0001, 0, 0));
        tbl.push_back(mk(8, 0, 8, 8, 'b1011, 1, 0, 0, 'b0000, 1, 8));
        tbl.push_back(mk(8, 0, 8, 8, 'b1011, 1, 1, 1, 'b0010, 0, 0));
        tbl.push_back(mk(8, 0, 0, 8, 'b1001, 1, 0, 0, 'b0000, 1, 8));
        tbl.push_back(mk(8, 0, 0, 8, 'b1001, 1, 1, 3, 'b1000, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8, 'b0001, 1, 0, 0, 'b0000, 1, 8));
        tbl.push_back(mk(0, 0, 0, 8, 'b0001, 1, 1, 0, 'b0001, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 'b0000, 1, 0, 0, 'b0000, 1, 8));
        tbl.push_back(mk(0, 0, 0, 0, 'b0000, 1, 0, 0, 'b0000, 0, 0));
        // Empty block on lane 1.
        tbl.push_back(mk(0, 0, 0, 0, 'b0010, 0, 0, 0, 'b0000, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 'b0010, 0, 1, 1, 'b0000, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 'b0000, 0, 0, 0, 'b0000, 1, 0));
        // Lane 3 stalls without end-of-block while lane 0 waits.
        tbl.push_back(mk(10, 0, 0, 5, 'b0001, 1, 0, 0, 'b0000, 0, 0));
        tbl.push_back(mk(10, 0, 0, 5, 'b0001, 1, 1, 3, 'b1000, 0, 0));
        for (int s = 0; s < 5; s++)
            tbl.push_back(mk(0, 0, 0, 5, 'b0001, 0, 1, 3, 'b0000, 0, 0));
        tbl.push_back(mk(0, 0, 0, 5, 'b1001, 0, 1, 3, 'b0000, 0, 0));
        tbl.push_back(mk(0, 0, 0, 5, 'b0001, 1, 0, 0, 'b0000, 1, 10));
        tbl.push_back(mk(0, 0, 0, 5, 'b0001, 1, 1, 0, 'b0001, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 'b0000, 1, 0, 0, 'b0000, 1, 5));

        do_reset();
        run_rows(0, 6);
        do_reset();
        run_rows(6, 16);
        run_rows(16, 19);
        run_rows(19, 30);

        // Reset during a lane 0 grant; afterwards lane 0 must win over lane 1.
        apply(mk(0, 0, 0, 40, 'b0000, 1, 0, 0, 'b0000, 0, 0), 1'b0, "rst0");
        apply(mk(0, 0, 0, 40, 'b0000, 1, 1, 0, 'b0001, 0, 0), 1'b0, "rst1");
        apply(mk(0, 0, 0, 40, 'b0000, 1, 1, 0, 'b0001, 0, 0), 1'b1, "rst2");
        apply(mk(0, 0, 8,  8, 'b0011, 1, 0, 0, 'b0000, 0, 0), 1'b0, "rst3");
        apply(mk(0, 0, 8,  8, 'b0011, 1, 1, 0, 'b0001, 0, 0), 1'b0, "rst4");
        apply(mk(0, 0, 8,  0, 'b0010, 1, 0, 0, 'b0000, 1, 8), 1'b0, "rst5");
        apply(mk(0, 0, 8,  0, 'b0010, 1, 1, 1, 'b0010, 0, 0), 1'b0, "rst6");
        apply(mk(0, 0, 0,  0, 'b0000, 1, 0, 0, 'b0000, 1, 8), 1'b0, "rst7");

        // Backpressure: five cycles of fifoShift=0 mid-block must not disturb the count.
        apply(mk(0, 40, 0, 0, 'b0000, 1, 0, 0, 'b0000, 0, 0), 1'b0, "bp0");
        apply(mk(0, 40, 0, 0, 'b0000, 1, 1, 2, 'b0100, 0, 0), 1'b0, "bp1");
        for (int s = 0; s < 5; s++)
            apply(mk(0, 24, 0, 0, 'b0000, 0, 1, 2, 'b0000, 0, 0), 1'b0, $sformatf("bp_hold%0d", s));
        apply(mk(0, 24, 0, 0, 'b0000, 1, 1, 2, 'b0100, 0, 0), 1'b0, "bp2");
        apply(mk(0,  8, 0, 0, 'b0100, 1, 1, 2, 'b0100, 0, 0), 1'b0, "bp3");
        apply(mk(0,  0, 0, 0, 'b0000, 1, 0, 0, 'b0000, 1, 40), 1'b0, "bp4");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
